// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: stage-register enables/clears, multicycle EX tracking, stall counter.
// Latency: outputs are combinational from state and inputs; state and counters update on the rising clock edge.
// Backpressure: mem_stall freezes everything upstream of MEM/WB and inserts a bubble into WB.
module pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mc,
    input  logic              ex_br_taken,
    input  logic              mem_stall,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_clr,
    output logic              idex_en,
    output logic              idex_clr,
    output logic              exmem_en,
    output logic              exmem_clr,
    output logic              memwb_en,
    output logic              memwb_clr,
    output logic              mc_done,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int CW = $clog2(MC_LAT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MC_LAT - 2);

    typedef enum logic {RUN, MC_BUSY} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          load_use;

    assign load_use = ex_memread && (ex_rd != '0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        ifid_clr  = 1'b0;
        idex_en   = 1'b1;
        idex_clr  = 1'b0;
        exmem_en  = 1'b1;
        exmem_clr = 1'b0;
        memwb_en  = 1'b1;
        memwb_clr = 1'b0;
        mc_done   = 1'b0;

        if (!rst) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            ifid_clr  = 1'b1;
            idex_en   = 1'b0;
            idex_clr  = 1'b1;
            exmem_en  = 1'b0;
            exmem_clr = 1'b1;
            memwb_en  = 1'b0;
            memwb_clr = 1'b1;
        end else if (mem_stall) begin
            // Hazards are re-evaluated once memory is ready, so nothing advances here.
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_clr = 1'b1;
        end else if ((state == RUN && ex_mc) || (state == MC_BUSY && cnt != '0)) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_clr = 1'b1;
            if (state == RUN) begin
                state_nx = MC_BUSY;
                cnt_nx   = CNT_LOAD;
            end else begin
                cnt_nx   = cnt - CW'(1);
            end
        end else if (state == MC_BUSY) begin
            mc_done  = 1'b1;
            state_nx = RUN;
        end else if (ex_br_taken) begin
            // The taken branch squashes the ID instruction, so any load-use on it is moot.
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
        end else if (load_use) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (!pc_en && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl plus a mid-cycle reset sequence during a multicycle op.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic       id_uses_rt = 1'b0, ex_memread = 1'b0, ex_mc = 1'b0;
    logic       ex_br_taken = 1'b0, mem_stall = 1'b0;

    logic        pc_en, ifid_en, ifid_clr, idex_en, idex_clr;
    logic        exmem_en, exmem_clr, memwb_en, memwb_clr, mc_done;
    logic [15:0] stall_cycles;
    logic        pc_en2, ifid_en2, ifid_clr2, idex_en2, idex_clr2;
    logic        exmem_en2, exmem_clr2, memwb_en2, memwb_clr2, mc_done2;
    logic [1:0]  stall_cycles2;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_mc(ex_mc), .ex_br_taken(ex_br_taken),
        .mem_stall(mem_stall), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr),
        .idex_en(idex_en), .idex_clr(idex_clr), .exmem_en(exmem_en), .exmem_clr(exmem_clr),
        .memwb_en(memwb_en), .memwb_clr(memwb_clr), .mc_done(mc_done),
        .stall_cycles(stall_cycles)
    );

    // Narrow-counter instance on the same stimulus, for saturation.
    pipe_hazard_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_mc(ex_mc), .ex_br_taken(ex_br_taken),
        .mem_stall(mem_stall), .pc_en(pc_en2), .ifid_en(ifid_en2), .ifid_clr(ifid_clr2),
        .idex_en(idex_en2), .idex_clr(idex_clr2), .exmem_en(exmem_en2), .exmem_clr(exmem_clr2),
        .memwb_en(memwb_en2), .memwb_clr(memwb_clr2), .mc_done(mc_done2),
        .stall_cycles(stall_cycles2)
    );

    // {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr, memwb_en, memwb_clr, mc_done}
    localparam logic [9:0] O_DEF = 10'b1101010100;
    localparam logic [9:0] O_RST = 10'b0010101010;
    localparam logic [9:0] O_LU  = 10'b0001110100;
    localparam logic [9:0] O_MC  = 10'b0000011100;
    localparam logic [9:0] O_MCD = 10'b1101010101;
    localparam logic [9:0] O_BR  = 10'b1111110100;
    localparam logic [9:0] O_MS  = 10'b0000000110;

    typedef struct {
        logic       r;
        logic [4:0] rs, rt;
        logic       urt, mr;
        logic [4:0] rd;
        logic       mc, br, ms;
        logic [9:0] eo;
        int         ec;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    wire [9:0] act = {pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
                      exmem_en, exmem_clr, memwb_en, memwb_clr, mc_done};

    task automatic add(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic mr, input logic [4:0] rd,
                       input logic mc, input logic br, input logic ms,
                       input logic [9:0] eo, input int ec);
        vec_t v;
        v.r = r; v.rs = rs; v.rt = rt; v.urt = urt; v.mr = mr; v.rd = rd;
        v.mc = mc; v.br = br; v.ms = ms; v.eo = eo; v.ec = ec;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, a, e);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.r; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.urt;
        ex_memread = v.mr; ex_rd = v.rd; ex_mc = v.mc; ex_br_taken = v.br; mem_stall = v.ms;
    endtask

    initial begin
        vec_t idle;
        idle = '{r:1'b1, rs:5'd0, rt:5'd0, urt:1'b0, mr:1'b0, rd:5'd0,
                 mc:1'b0, br:1'b0, ms:1'b0, eo:O_DEF, ec:0};

        //   r  rs  rt urt mr rd  mc br ms  out    cnt
        add(0, 0,  0, 0,  0, 0,  0, 0, 0, O_RST,  0);  // reset
        add(1, 0,  0, 0,  0, 0,  0, 0, 0, O_DEF,  0);
        add(1, 5,  0, 0,  1, 5,  0, 0, 0, O_LU,   0);  // load-use on rs
        add(1, 0,  0, 0,  1, 0,  0, 0, 0, O_DEF,  1);  // rd=0 never hazards
        add(1, 3,  7, 1,  1, 7,  0, 0, 0, O_LU,   1);  // load-use on rt
        add(1, 2,  7, 0,  1, 7,  0, 0, 0, O_DEF,  2);  // rt not read
        add(1, 0,  0, 0,  0, 0,  1, 0, 0, O_MC,   2);  // multicycle, ex_mc held
        add(1, 0,  0, 0,  0, 0,  1, 0, 0, O_MC,   3);
        add(1, 0,  0, 0,  0, 0,  1, 0, 0, O_MC,   4);
        add(1, 0,  0, 0,  0, 0,  1, 0, 0, O_MCD,  5);
        add(1, 0,  0, 0,  0, 0,  0, 0, 0, O_DEF,  5);
        add(1, 5,  0, 0,  1, 5,  0, 1, 0, O_BR,   5);  // branch beats load-use
        add(1, 0,  0, 0,  0, 0,  0, 0, 0, O_DEF,  5);
        add(1, 0,  0, 0,  0, 0,  1, 0, 0, O_MC,   5);  // multicycle with mem stall at cnt=1
        add(1, 0,  0, 0,  0, 0,  0, 0, 0, O_MC,   6);
        add(1, 0,  0, 0,  0, 0,  0, 0, 1, O_MS,   7);
        add(1, 0,  0, 0,  0, 0,  0, 0, 1, O_MS,   8);
        add(1, 0,  0, 0,  0, 0,  0, 0, 0, O_MC,   9);
        add(1, 0,  0, 0,  0, 0,  0, 0, 0, O_MCD, 10);
        add(1, 0,  0, 0,  0, 0,  0, 0, 0, O_DEF, 10);
        add(1, 5,  0, 0,  1, 5,  0, 1, 1, O_MS,  10);  // mem stall masks branch and load-use
        add(1, 0,  0, 0,  0, 0,  0, 1, 0, O_BR,  11);
        add(1, 0,  0, 0,  0, 0,  1, 0, 0, O_MC,  11);  // reset in MC_BUSY
        add(1, 0,  0, 0,  0, 0,  0, 0, 0, O_MC,  12);
        add(0, 0,  0, 0,  0, 0,  0, 0, 0, O_RST,  0);
        add(1, 0,  0, 0,  0, 0,  0, 0, 0, O_DEF,  0);
        add(1, 0,  0, 0,  0, 0,  1, 0, 0, O_MC,   0);
        add(1, 0,  0, 0,  0, 0,  0, 0, 0, O_MC,   1);
        add(1, 0,  0, 0,  0, 0,  0, 0, 0, O_MC,   2);
        add(1, 0,  0, 0,  0, 0,  0, 0, 0, O_MCD,  3);
        add(1, 0,  0, 0,  0, 0,  0, 0, 0, O_DEF,  3);
        add(1, 0,  0, 0,  0, 0,  0, 0, 1, O_MS,   3);
        add(1, 0,  0, 0,  0, 0,  0, 0, 0, O_DEF,  4);  // narrow counter stuck at 3

        drive(tbl[0]);
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("v%0d outputs", i), 32'(act), 32'(tbl[i].eo));
            chk($sformatf("v%0d stall_cycles", i), 32'(stall_cycles), 32'(tbl[i].ec));
            chk($sformatf("v%0d stall_cycles_sat", i), 32'(stall_cycles2),
                32'((tbl[i].ec > 3) ? 3 : tbl[i].ec));
        end

        // Asynchronous reset asserted mid-cycle while a multicycle op is in EX.
        @(posedge clk); #1;
        drive(idle);
        ex_mc = 1'b1;
        @(negedge clk);
        chk("mc start", 32'(act), 32'(O_MC));
        @(posedge clk); #1;
        ex_mc = 1'b0;
        @(negedge clk);
        chk("mc busy", 32'(act), 32'(O_MC));
        chk("mc busy count", 32'(stall_cycles), 32'd5);
        #1 rst = 1'b0;
        #1;
        chk("async rst outputs", 32'(act), 32'(O_RST));
        chk("async rst count", 32'(stall_cycles), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post rst run", 32'(act), 32'(O_DEF));
        @(posedge clk);
        @(negedge clk);
        chk("post rst no mc_done", 32'(act), 32'(O_DEF));
        chk("post rst count", 32'(stall_cycles), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
